// File: rtl/prga_prog_pkg.sv
// prga_prog_pkg
//   Shared definitions for the PRGA bitstream loader: Wishbone register
//   offsets (word index taken from adr[3:2]), CTRL bit positions, STATUS
//   field positions, the serializer state encoding and a STATUS packer.
package prga_prog_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_BITCNT = 2'd3;

  localparam int CTRL_SOFT_RST = 0;
  localparam int CTRL_DONE_REQ = 1;
  localparam int CTRL_DONE_CLR = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_PENDING   = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RST   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] pack_status(input logic [7:0] count,
                                              input logic       pending,
                                              input logic       busy,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: 8] = count;
    s[STAT_PENDING]        = pending;
    s[STAT_BUSY]           = busy;
    s[STAT_FULL]           = full;
    s[STAT_EMPTY]          = empty;
    return s;
  endfunction

endpackage

// File: rtl/prga_prog_fifo.sv
// prga_prog_fifo
//   Synchronous first-word-fall-through FIFO. dout always shows the oldest
//   entry; pop consumes it. Pushes while full and pops while empty are
//   ignored. flush empties the FIFO in one cycle and wins over push/pop.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               discard all contents
//   push, din           write one entry
//   pop, dout           consume / observe the oldest entry
//   full, empty, count  occupancy
module prga_prog_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/prga_prog_loader.sv
// prga_prog_loader
//   Wishbone-slave bitstream loader for the PRGA configuration chain.
//   Firmware writes 32-bit words to DATA; they are buffered and shifted out
//   MSB-first on prog_din with prog_we marking each valid bit. CTRL sequences
//   the fabric configuration reset (prog_rst) and the done flag (prog_done).
// Ports:
//   wb_clk_i, wb_rst_n          clock (also fabric prog_clk), async active-low reset
//   wbs_cyc_i/stb_i/we_i        Wishbone classic control
//   wbs_adr_i, wbs_dat_i        byte address (adr[3:2] decoded), write data
//   wbs_sel_i                   ignored, writes are full-word
//   wbs_ack_o, wbs_dat_o        registered acknowledge, read data (0 when no ack)
//   prog_rst, prog_we,
//   prog_din, prog_done         fabric programming interface
// Handshake: a transfer is requested while cyc&stb are high and ack is low.
//   ack is registered, high for exactly one cycle, and the register side
//   effect (push / CTRL action) happens on the edge that raises ack. A DATA
//   write against a full FIFO simply keeps the request pending.
module prga_prog_loader
  import prga_prog_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_rst,
  output logic        prog_we,
  output logic        prog_din,
  output logic        prog_done
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);

  state_t           state, state_next;
  logic [31:0]      sreg;
  logic [4:0]       bit_idx;
  logic [31:0]      bitcnt;
  logic [RCW-1:0]   rst_cnt;
  logic             soft_rst_pend;
  logic             pending_done;

  logic [31:0]      fifo_dout;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]    fifo_count;

  logic [1:0]       reg_sel;
  logic             wb_req, wb_stall, wb_take;
  logic             data_push, ctrl_wr;
  logic             soft_rst_wr, done_req_wr, done_clr_wr;
  logic             sreg_load, shift_en, enter_done;
  logic             busy;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // ---------------- Wishbone decode ----------------
  assign reg_sel  = wbs_adr_i[3:2];
  assign wb_req   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wb_stall = wbs_we_i & (reg_sel == REG_DATA) & fifo_full;
  assign wb_take  = wb_req & ~wb_stall;

  assign data_push   = wb_take & wbs_we_i & (reg_sel == REG_DATA);
  assign ctrl_wr     = wb_take & wbs_we_i & (reg_sel == REG_CTRL);
  assign soft_rst_wr = ctrl_wr & wbs_dat_i[CTRL_SOFT_RST];
  // SOFT_RST in the same write swallows DONE_REQ.
  assign done_req_wr = ctrl_wr & wbs_dat_i[CTRL_DONE_REQ] & ~wbs_dat_i[CTRL_SOFT_RST];
  assign done_clr_wr = ctrl_wr & wbs_dat_i[CTRL_DONE_CLR];

  assign busy = (state == ST_SHIFT) || (state == ST_RST);

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_STATUS: rd_data = pack_status(8'(fifo_count), pending_done, busy,
                                        fifo_full, fifo_empty);
      REG_BITCNT: rd_data = bitcnt;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_take;
      wbs_dat_o <= (wb_take && !wbs_we_i) ? rd_data : '0;
    end
  end

  // ---------------- word FIFO ----------------
  prga_prog_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .flush (soft_rst_wr),
    .push  (data_push),
    .din   (wbs_dat_i),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- serializer FSM ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    sreg_load  = 1'b0;
    shift_en   = 1'b0;
    enter_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (soft_rst_pend) begin
          state_next = ST_RST;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          sreg_load  = 1'b1;
          state_next = ST_SHIFT;
        end else if (pending_done && !data_push) begin
          // A word landing this edge must be shifted before done is shown.
          enter_done = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (bit_idx == 5'd31) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            sreg_load = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_RST: begin
        if (rst_cnt == RCW'(RST_CYCLES - 1)) state_next = ST_IDLE;
      end
      ST_DONE: begin
        if (done_clr_wr || data_push || !fifo_empty) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // SOFT_RST aborts everything; IDLE then launches the prog_rst pulse.
    if (soft_rst_wr) begin
      state_next = ST_IDLE;
      fifo_pop   = 1'b0;
      sreg_load  = 1'b0;
      shift_en   = 1'b0;
      enter_done = 1'b0;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sreg          <= '0;
      bit_idx       <= '0;
      bitcnt        <= '0;
      rst_cnt       <= '0;
      soft_rst_pend <= 1'b0;
      pending_done  <= 1'b0;
    end else begin
      if (sreg_load) begin
        sreg    <= fifo_dout;
        bit_idx <= '0;
      end else if (shift_en) begin
        sreg    <= {sreg[30:0], 1'b0};
        bit_idx <= bit_idx + 5'd1;
      end

      if (soft_rst_wr)   bitcnt <= '0;
      else if (shift_en) bitcnt <= bitcnt + 32'd1;

      if (state == ST_RST) rst_cnt <= rst_cnt + 1'b1;
      else                 rst_cnt <= '0;

      // IDLE always converts a pending soft reset into the RST state.
      if (soft_rst_wr)            soft_rst_pend <= 1'b1;
      else if (state == ST_IDLE)  soft_rst_pend <= 1'b0;

      if (soft_rst_wr)      pending_done <= 1'b0;
      else if (done_req_wr) pending_done <= 1'b1;
      else if (enter_done)  pending_done <= 1'b0;
    end
  end

  assign prog_we   = (state == ST_SHIFT);
  assign prog_din  = prog_we & sreg[31];
  assign prog_rst  = (state == ST_RST);
  assign prog_done = (state == ST_DONE);

endmodule

// File: tb/tb_prga_prog_loader.sv
module tb_prga_prog_loader;
  import prga_prog_pkg::*;

  localparam int DEPTH = 4;
  localparam int RSTC  = 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        prog_rst, prog_we, prog_din, prog_done;

  prga_prog_loader #(
    .FIFO_DEPTH (DEPTH),
    .RST_CYCLES (RSTC)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .prog_rst  (prog_rst),
    .prog_we   (prog_we),
    .prog_din  (prog_din),
    .prog_done (prog_done)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0] exp_q[$];
  logic [0:0] exp_bit;
  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;
  int run_len = 0, last_run = 0, last_we_cyc = 0;
  int rst_len = 0, rst_last_run = 0, rst_first_cyc = 0;
  int last_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc_n++;

  // Monitor: consume one expected bit per prog_we cycle, track run lengths.
  always @(negedge clk) begin
    if (prog_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 32'(prog_we), 32'd0);
      end else begin
        exp_bit = exp_q.pop_front();
        check("prog_din", 32'(prog_din), 32'(exp_bit));
      end
      run_len++;
      last_we_cyc = cyc_n;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (prog_rst) begin
      if (rst_len == 0) rst_first_cyc = cyc_n;
      rst_len++;
    end else if (rst_len != 0) begin
      rst_last_run = rst_len;
      rst_len      = 0;
    end
    if (!wbs_ack_o) check("dat_o_idle", wbs_dat_o, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [1:0] sel, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int waited);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = {28'h0, sel, 2'b00};
    wbs_dat_i = wdata;
    wbs_sel_i = 4'hF;
    waited    = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!wbs_ack_o && waited < 200);
    if (!wbs_ack_o) check("ack_timeout", 32'd0, 32'd1);
    rdata     = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] sel, input logic [31:0] data, output int waited);
    logic [31:0] dummy;
    wb_xfer(1'b1, sel, data, dummy, waited);
    if (sel == REG_DATA)
      for (int b = 31; b >= 0; b--) exp_q.push_back(data[b]);
    if (sel == REG_CTRL && data[CTRL_SOFT_RST]) begin
      last_drop = exp_q.size();
      exp_q.delete();
    end
  endtask

  task automatic wb_read(input logic [1:0] sel, output logic [31:0] data);
    int w;
    wb_xfer(1'b0, sel, 32'h0, data, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    done_cyc = -1;
    while (n < 500) begin
      @(negedge clk);
      n++;
      if (prog_done) begin
        done_cyc = cyc_n;
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int w, dc, ack_cyc;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; wbs_sel_i = 0;

    // Reset values
    idle(3);
    check("reset_outputs", {27'd0, wbs_ack_o, prog_rst, prog_we, prog_din, prog_done}, 32'd0);
    check("reset_dat_o", wbs_dat_o, 32'd0);
    rst_n = 1'b1;
    idle(1);
    wb_read(REG_STATUS, rd); check("status_reset", rd, 32'h0000_0001);
    wb_read(REG_BITCNT, rd); check("bitcnt_reset", rd, 32'd0);

    // Single word then DONE_REQ
    idle(1);
    wb_write(REG_DATA, 32'hA500_0001, w);
    @(negedge clk); check("we_in_ack_cycle", 32'(prog_we), 32'd0);
    @(negedge clk); check("first_bit_latency", 32'(prog_we), 32'd1);
    wb_write(REG_CTRL, 32'h2, w);
    wait_done(dc);
    check("done_delay_1", dc - last_we_cyc, 32'd2);
    check("run_len_1word", last_run, 32'd32);
    check("queue_drained_1", exp_q.size(), 32'd0);
    idle(1);
    wb_read(REG_BITCNT, rd); check("bitcnt_32", rd, 32'd32);
    wb_read(REG_STATUS, rd); check("status_done", rd, 32'h0000_0001);

    // Push while done, fill the FIFO, then a stalled write
    idle(1);
    wb_write(REG_DATA, $urandom, w);
    check("done_drop_on_push", 32'(prog_done), 32'd0);
    for (int i = 0; i < 4; i++) wb_write(REG_DATA, $urandom, w);
    wb_write(REG_DATA, $urandom, w);
    check("stall_when_full", 32'(w > 10), 32'd1);
    wb_read(REG_STATUS, rd); check("status_busy_full", rd, 32'h0000_0406);
    wb_write(REG_CTRL, 32'h2, w);
    wb_read(REG_STATUS, rd); check("status_pending", rd, 32'h0000_040E);
    wait_done(dc);
    check("done_delay_6", dc - last_we_cyc, 32'd2);
    check("run_len_6words", last_run, 32'd192);
    idle(1);
    wb_read(REG_BITCNT, rd); check("bitcnt_224", rd, 32'd224);

    // SOFT_RST mid-word
    idle(1);
    wb_write(REG_DATA, $urandom, w);
    idle(10);
    wb_write(REG_CTRL, 32'h1, w);
    ack_cyc = cyc_n;
    check("abort_we", 32'(prog_we), 32'd0);
    check("abort_bits_dropped", last_drop, 32'd22);
    idle(RSTC + 4);
    check("rst_len", rst_last_run, RSTC);
    check("rst_start", rst_first_cyc, ack_cyc + 1);
    wb_read(REG_STATUS, rd); check("status_after_soft", rd, 32'h0000_0001);
    wb_read(REG_BITCNT, rd); check("bitcnt_after_soft", rd, 32'd0);

    // DONE_REQ together with SOFT_RST
    idle(1);
    wb_write(REG_CTRL, 32'h3, w);
    idle(RSTC + 6);
    check("soft_wins_done", 32'(prog_done), 32'd0);
    wb_read(REG_STATUS, rd); check("status_no_pending", rd, 32'h0000_0001);

    // Read-only write and write-only read
    idle(1);
    wb_write(REG_STATUS, 32'hFFFF_FFFF, w);
    check("ro_write_ack_1cyc", w, 32'd1);
    wb_read(REG_DATA, rd); check("data_read_zero", rd, 32'd0);
    wb_read(REG_STATUS, rd); check("status_unchanged", rd, 32'h0000_0001);

    // DONE_REQ while idle, then DONE_CLR
    idle(1);
    wb_write(REG_CTRL, 32'h2, w);
    @(negedge clk); check("done_not_in_ack", 32'(prog_done), 32'd0);
    @(negedge clk); check("done_rise_idle", 32'(prog_done), 32'd1);
    wb_write(REG_CTRL, 32'h4, w);
    check("done_clr", 32'(prog_done), 32'd0);

    // Asynchronous reset mid-SHIFT
    idle(1);
    wb_write(REG_DATA, $urandom, w);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {27'd0, wbs_ack_o, prog_rst, prog_we, prog_din, prog_done}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    wb_read(REG_BITCNT, rd); check("bitcnt_after_async", rd, 32'd0);
    wb_read(REG_STATUS, rd); check("status_after_async", rd, 32'h0000_0001);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
